regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32-entry × 32-bit register file between NREQ requesters.
- Requester 0 is the pipeline writeback stage. Requesters 1..NREQ-1 are secondary writers: the multdiv unit and the game I/O / controller-input unit.
- Requester 0 has fixed priority. Secondary requesters rotate round-robin among themselves. A per-requester starvation counter forces a grant when a secondary requester has waited too long, and the pipeline is stalled while that happens.
- Write command to the register file is registered: one cycle of latency.

---
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the register-file requesters and the arbiter.
// The arbiter takes the slave modport.
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic                   stall_wb;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_addr;
    logic [DATA_W-1:0]      rf_data;

    modport master (
        output req, req_addr, req_data,
        input  ack, stall_wb, rf_we, rf_addr, rf_data
    );

    modport slave (
        input  req, req_addr, req_data,
        output ack, stall_wb, rf_we, rf_addr, rf_data
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port. Writeback has fixed priority,
// secondaries rotate round-robin, and a starved secondary forces a grant.
module regfile_write_arbiter #(
    parameter int NREQ     = 3,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   bus
);
    localparam int IDX_W = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  wait_cnt_q [1:NREQ-1];
    logic [CNT_W-1:0]  wait_cnt_d [1:NREQ-1];
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic              starve_hit, rr_hit, grant_hit;
    logic [IDX_W-1:0]  starve_idx, rr_idx, grant_idx;
    logic [NREQ-1:0]   ack_w;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    int                cand;

    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        // Descending scan so the lowest starved index is the one left standing.
        for (int i = NREQ - 1; i >= 1; i--) begin
            if (bus.req[i] && wait_cnt_q[i] == CNT_W'(MAX_WAIT)) begin
                starve_hit = 1'b1;
                starve_idx = IDX_W'(i);
            end
        end

        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = 0;
        for (int k = NREQ - 1; k >= 1; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand > NREQ - 1) begin
                cand = cand - (NREQ - 1);
            end
            if (bus.req[IDX_W'(cand)]) begin
                rr_hit = 1'b1;
                rr_idx = IDX_W'(cand);
            end
        end

        grant_hit = 1'b0;
        grant_idx = '0;
        if (reset) begin
            grant_hit = 1'b0;
        end else if (starve_hit) begin
            grant_hit = 1'b1;
            grant_idx = starve_idx;
        end else if (bus.req[0]) begin
            grant_hit = 1'b1;
            grant_idx = '0;
        end else if (rr_hit) begin
            grant_hit = 1'b1;
            grant_idx = rr_idx;
        end

        ack_w = '0;
        if (grant_hit) begin
            ack_w = NREQ'(1) << grant_idx;
        end

        g_addr = '0;
        g_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_w[i]) begin
                g_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                g_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_hit && grant_idx != '0) begin
            rr_ptr_d = grant_idx;
        end

        for (int i = 1; i < NREQ; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (ack_w[i] || !bus.req[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] != CNT_W'(MAX_WAIT)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + CNT_W'(1);
            end
        end

        // Address 0 is hard-wired in the register file: ack it but drop the write.
        rf_we_d   = grant_hit && (g_addr != '0);
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (grant_hit) begin
            rf_addr_d = g_addr;
            rf_data_d = g_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q  <= IDX_W'(NREQ - 1);
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            for (int i = 1; i < NREQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            for (int i = 1; i < NREQ; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    assign bus.ack      = ack_w;
    assign bus.stall_wb = ~reset & bus.req[0] & ~ack_w[0];
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_data  = rf_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised scoreboard bench for regfile_write_arbiter: a rule-level model
// predicts grants and write commands; a monitor checks the registered writes.
module tb_regfile_write_arbiter;
    localparam int NREQ     = 3;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    regfile_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    regfile_write_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    wr_t exp_q[$];

    logic              r_v [NREQ];
    logic [ADDR_W-1:0] a_v [NREQ];
    logic [DATA_W-1:0] d_v [NREQ];

    int                m_rr;
    int                m_wait [NREQ];
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [NREQ-1:0]   last_ack;
    logic [NREQ-1:0]   seen_ack;
    logic              seen_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic rst);
        logic [NREQ-1:0] exp_ack;
        logic            exp_stall;
        int              g;
        int              c;
        wr_t             w;
        @(negedge clock);
        reset = rst;
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i] = r_v[i];
            bus.req_addr[i*ADDR_W +: ADDR_W] = a_v[i];
            bus.req_data[i*DATA_W +: DATA_W] = d_v[i];
        end
        #1;
        g = -1;
        if (!rst) begin
            for (int i = 1; i < NREQ; i++)
                if (g < 0 && r_v[i] && m_wait[i] == MAX_WAIT) g = i;
            if (g < 0 && r_v[0]) g = 0;
            for (int k = 1; k < NREQ; k++) begin
                c = (m_rr - 1 + k) % (NREQ - 1) + 1;
                if (g < 0 && r_v[c]) g = c;
            end
        end
        exp_ack   = (g >= 0) ? (NREQ'(1) << g) : '0;
        exp_stall = !rst && r_v[0] && (g != 0);
        seen_ack   = bus.ack;
        seen_stall = bus.stall_wb;
        check("ack", 64'(bus.ack), 64'(exp_ack));
        check("stall_wb", 64'(bus.stall_wb), 64'(exp_stall));
        last_ack = exp_ack;

        if (rst) begin
            m_rr = NREQ - 1;
            for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
            m_addr = '0;
            m_data = '0;
            w.we   = 1'b0;
        end else begin
            for (int i = 1; i < NREQ; i++)
                m_wait[i] = (!r_v[i] || g == i) ? 0 :
                            (m_wait[i] < MAX_WAIT) ? m_wait[i] + 1 : MAX_WAIT;
            if (g > 0) m_rr = g;
            if (g >= 0) begin
                m_addr = a_v[g];
                m_data = d_v[g];
                w.we   = (a_v[g] != '0);
            end else begin
                w.we = 1'b0;
            end
        end
        w.addr = m_addr;
        w.data = m_data;
        exp_q.push_back(w);
    endtask

    initial begin
        wr_t w;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("rf_we", 64'(bus.rf_we), 64'(w.we));
                check("rf_addr", 64'(bus.rf_addr), 64'(w.addr));
                check("rf_data", 64'(bus.rf_data), 64'(w.data));
            end
        end
    end

    task automatic set_req(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) r_v[i] = r[i];
    endtask

    task automatic new_payload(input int i);
        a_v[i] = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(1, 31));
        d_v[i] = $urandom;
    endtask

    task automatic gen();
        for (int i = 0; i < NREQ; i++) begin
            if (last_ack[i]) begin
                r_v[i] = ($urandom_range(0, 3) != 0);
                new_payload(i);
            end else if (!r_v[i]) begin
                r_v[i] = (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
                if (r_v[i]) new_payload(i);
            end else if ($urandom_range(0, 15) == 0) begin
                r_v[i] = 1'b0;
            end
        end
    endtask

    initial begin
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        last_ack     = '0;
        for (int i = 0; i < NREQ; i++) begin
            r_v[i] = 1'b0; a_v[i] = '0; d_v[i] = '0; m_wait[i] = 0;
        end
        m_rr = NREQ - 1; m_addr = '0; m_data = '0;

        step(1); step(1);

        a_v[1] = 5'd3; d_v[1] = 32'h1111_0001;
        a_v[2] = 5'd7; d_v[2] = 32'h2222_0002;
        set_req(3'b110);
        step(0);
        check("first_rr", 64'(seen_ack), 64'(3'b010));
        for (int k = 0; k < 5; k++) begin
            step(0);
            check("rr_alt", 64'(seen_ack), (k % 2 == 0) ? 64'(3'b100) : 64'(3'b010));
        end

        set_req(3'b000); step(0);
        a_v[0] = 5'd5; d_v[0] = 32'hDEAD_BEEF;
        set_req(3'b001); step(0);
        check("wb_ack", 64'(seen_ack), 64'(3'b001));
        check("wb_nostall", 64'(seen_stall), 64'(1'b0));
        set_req(3'b000); step(0);

        a_v[1] = 5'd9; d_v[1] = 32'hCAFE_0009;
        set_req(3'b011);
        for (int c = 0; c < 6; c++) begin
            step(0);
            check("starve_seq", 64'(seen_ack), (c == 4) ? 64'(3'b010) : 64'(3'b001));
            if (c == 4) check("starve_stall", 64'(seen_stall), 64'(1'b1));
        end

        set_req(3'b000); step(0);
        a_v[2] = 5'd0; d_v[2] = 32'h1234_5678;
        set_req(3'b100); step(0);
        check("addr0_ack", 64'(seen_ack), 64'(3'b100));
        set_req(3'b000); step(0);

        set_req(3'b011);
        for (int c = 0; c < 3; c++) step(0);
        step(1);
        check("reset_noack", 64'(seen_ack), 64'(3'b000));
        check("reset_nostall", 64'(seen_stall), 64'(1'b0));
        for (int c = 0; c < 5; c++) begin
            step(0);
            check("post_reset", 64'(seen_ack), (c == 4) ? 64'(3'b010) : 64'(3'b001));
        end
        set_req(3'b000); step(0);

        for (int n = 0; n < 4000; n++) begin
            gen();
            step($urandom_range(0, 199) == 0);
        end

        set_req(3'b000);
        step(0); step(0);
        @(posedge clock);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
